// File: rtl/lc4_pkg.sv
// rtl/lc4_pkg.sv - shared LC4 opcodes, width defaults, nzp encoding and decode helpers
package lc4_pkg;

  localparam int WORD_SIZE_DEF = 64;
  localparam int IADDR_DEF     = 10;
  localparam int INSN_DEF      = 19;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  localparam logic [4:0] OP_NOP     = 5'd0;
  localparam logic [4:0] OP_BRZ     = 5'd1;
  localparam logic [4:0] OP_BRZP    = 5'd2;
  localparam logic [4:0] OP_BRNP    = 5'd3;
  localparam logic [4:0] OP_BRNZ    = 5'd4;
  localparam logic [4:0] OP_ADD     = 5'd5;
  localparam logic [4:0] OP_SUB     = 5'd6;
  localparam logic [4:0] OP_MUL     = 5'd7;
  localparam logic [4:0] OP_JSR     = 5'd8;
  localparam logic [4:0] OP_CONST   = 5'd9;
  localparam logic [4:0] OP_HICONST = 5'd10;
  localparam logic [4:0] OP_AND     = 5'd11;
  localparam logic [4:0] OP_OR      = 5'd12;
  localparam logic [4:0] OP_XOR     = 5'd13;
  localparam logic [4:0] OP_NOT     = 5'd14;
  localparam logic [4:0] OP_SLL     = 5'd15;
  localparam logic [4:0] OP_CHK     = 5'd16;
  localparam logic [4:0] OP_STR     = 5'd17;
  localparam logic [4:0] OP_SRL     = 5'd18;
  localparam logic [4:0] OP_SRA     = 5'd19;
  localparam logic [4:0] OP_TCS     = 5'd20;
  localparam logic [4:0] OP_LDR     = 5'd21;

  function automatic logic is_writer(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_CONST, OP_HICONST,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SLL, OP_CHK,
      OP_SRL, OP_SRA, OP_TCS, OP_LDR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // nzp is the flag state before this instruction; bit order {N,Z,P}
  function automatic logic br_cond(input logic [4:0] op, input logic [2:0] nzp);
    case (op)
      OP_BRZ:  return nzp[1];
      OP_BRZP: return nzp[1] | nzp[0];
      OP_BRNP: return nzp[2] | nzp[0];
      OP_BRNZ: return nzp[2] | nzp[1];
      OP_JSR:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lc4_wb_stage_if.sv
// rtl/lc4_wb_stage_if.sv - writeback entry handshake bundle with producer/consumer modports
interface lc4_wb_stage_if #(
  parameter int WORD_SIZE = lc4_pkg::WORD_SIZE_DEF,
  parameter int IADDR     = lc4_pkg::IADDR_DEF
);

  logic                 valid;
  logic                 ready;
  logic                 we;
  logic [4:0]           wsel;
  logic [WORD_SIZE-1:0] wdata;
  logic                 br_taken;
  logic [IADDR:0]       br_target;

  modport master (
    output valid, we, wsel, wdata, br_taken, br_target,
    input  ready
  );

  modport slave (
    input  valid, we, wsel, wdata, br_taken, br_target,
    output ready
  );

endinterface

// File: rtl/lc4_skid_buf.sv
// rtl/lc4_skid_buf.sv - writeback entry buffer; LC4_WB_SKID_EN selects a 2-entry skid
// buffer with registered ready, otherwise a single pass-through register.
module lc4_skid_buf import lc4_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int IADDR     = IADDR_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  lc4_wb_stage_if.slave  in_bus,
  lc4_wb_stage_if.master out_bus
);

  localparam int PW = WORD_SIZE + IADDR + 8;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;
  logic          out_v;

  assign in_pl = {in_bus.we, in_bus.wsel, in_bus.wdata, in_bus.br_taken, in_bus.br_target};
  assign {out_bus.we, out_bus.wsel, out_bus.wdata, out_bus.br_taken, out_bus.br_target} = out_pl;
  assign out_bus.valid = out_v;

`ifdef LC4_WB_SKID_EN
  logic [PW-1:0] sk_pl;
  logic          sk_v;
  logic          ready_q;
  logic          push;

  assign in_bus.ready = ready_q;
  assign push         = in_bus.valid && ready_q;

  // ready_q always mirrors "skid slot free" for the coming cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v   <= 1'b0;
      out_pl  <= '0;
      sk_v    <= 1'b0;
      sk_pl   <= '0;
      ready_q <= 1'b1;
    end else if (!out_v || out_bus.ready) begin
      ready_q <= 1'b1;
      if (sk_v) begin
        out_pl <= sk_pl;
        out_v  <= 1'b1;
        sk_v   <= 1'b0;
      end else begin
        out_v <= push;
        if (push) out_pl <= in_pl;
      end
    end else if (push) begin
      sk_pl   <= in_pl;
      sk_v    <= 1'b1;
      ready_q <= 1'b0;
    end
  end
`else
  assign in_bus.ready = !out_v || out_bus.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      out_pl <= '0;
    end else if (in_bus.ready) begin
      out_v <= in_bus.valid;
      if (in_bus.valid) out_pl <= in_pl;
    end
  end
`endif

endmodule

// File: rtl/lc4_wb_stage.sv
// rtl/lc4_wb_stage.sv - LC4 writeback stage: decode, flags, branch resolve, squash.
// Buffering depth follows LC4_WB_SKID_EN (see lc4_skid_buf).
module lc4_wb_stage import lc4_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int IADDR     = IADDR_DEF,
  parameter int INSN      = INSN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [INSN:0]        i_insn,
  input  logic [IADDR:0]       i_pc,
  input  logic [WORD_SIZE-1:0] i_result,
  output logic                 o_valid,
  input  logic                 i_wb_ready,
  output logic                 o_we,
  output logic [4:0]           o_wsel,
  output logic [WORD_SIZE-1:0] o_wdata,
  output logic [2:0]           o_nzp,
  output logic                 o_carry,
  output logic                 o_br_taken,
  output logic [IADDR:0]       o_br_target
);

  lc4_wb_stage_if #(.WORD_SIZE(WORD_SIZE), .IADDR(IADDR)) in_bus ();
  lc4_wb_stage_if #(.WORD_SIZE(WORD_SIZE), .IADDR(IADDR)) out_bus ();

  logic [2:0] nzp_q;
  logic       carry_q;
  logic       squash_q;
  logic [4:0] opcode;
  logic [4:0] rd;
  logic       writer;
  logic       taken;
  logic       accept;
  logic [2:0] res_nzp;
  logic       unused_pc;

  assign unused_pc = ^i_pc;

  assign opcode  = i_insn[INSN -: 5];
  assign rd      = i_insn[INSN-5 -: 5];
  assign writer  = is_writer(opcode);
  assign taken   = br_cond(opcode, nzp_q);
  assign accept  = i_valid && o_ready;
  assign res_nzp = i_result[WORD_SIZE-1] ? NZP_N :
                   (i_result == '0)       ? NZP_Z : NZP_P;

  // a squashed instruction is still consumed, it just never reaches the buffer
  assign in_bus.valid     = i_valid && !squash_q;
  assign in_bus.we        = writer;
  assign in_bus.wsel      = writer ? rd : 5'd0;
  assign in_bus.wdata     = writer ? i_result : '0;
  assign in_bus.br_taken  = taken;
  assign in_bus.br_target = taken ? i_result[IADDR:0] : '0;
  assign o_ready          = in_bus.ready;

  lc4_skid_buf #(.WORD_SIZE(WORD_SIZE), .IADDR(IADDR)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus.slave),
    .out_bus (out_bus.master)
  );

  assign out_bus.ready = i_wb_ready;
  assign o_valid       = out_bus.valid;
  assign o_we          = out_bus.we;
  assign o_wsel        = out_bus.wsel;
  assign o_wdata       = out_bus.wdata;
  assign o_br_taken    = out_bus.br_taken;
  assign o_br_target   = out_bus.br_target;
  assign o_nzp         = nzp_q;
  assign o_carry       = carry_q;

  // flags move at accept, so a branch right behind its producer sees the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp_q    <= NZP_Z;
      carry_q  <= 1'b0;
      squash_q <= 1'b0;
    end else if (accept) begin
      if (squash_q) begin
        squash_q <= 1'b0;
      end else begin
        if (writer) nzp_q <= res_nzp;
        if (opcode == OP_CHK)      carry_q <= i_result[0];
        else if (opcode == OP_TCS) carry_q <= 1'b0;
        squash_q <= taken;
      end
    end
  end

endmodule

// File: tb/tb_lc4_wb_stage.sv
// tb/tb_lc4_wb_stage.sv - randomized self-checking bench for lc4_wb_stage against a queue model
module tb_lc4_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_wb_ready;
  logic [19:0] i_insn;
  logic [10:0] i_pc;
  logic [63:0] i_result;
  logic [2:0]  o_nzp;
  logic        o_carry;

  always #5 clk = ~clk;

  lc4_wb_stage_if #(.WORD_SIZE(64), .IADDR(10)) mon ();

  lc4_wb_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_ready     (mon.ready),
    .i_insn      (i_insn),
    .i_pc        (i_pc),
    .i_result    (i_result),
    .o_valid     (mon.valid),
    .i_wb_ready  (i_wb_ready),
    .o_we        (mon.we),
    .o_wsel      (mon.wsel),
    .o_wdata     (mon.wdata),
    .o_nzp       (o_nzp),
    .o_carry     (o_carry),
    .o_br_taken  (mon.br_taken),
    .o_br_target (mon.br_target)
  );

`ifdef LC4_WB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    bit        we;
    bit [4:0]  wsel;
    bit [63:0] wdata;
    bit        br;
    bit [10:0] tgt;
  } ent_t;

  ent_t     q[$];
  bit [2:0] m_nzp;
  bit       m_carry;
  bit       m_squash;
  int       checks   = 0;
  int       failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready(input bit wbr);
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || wbr;
  endfunction

  task automatic model_clear();
    q.delete();
    m_nzp    = 3'b010;
    m_carry  = 1'b0;
    m_squash = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("valid", mon.valid, q.size() > 0);
    if (q.size() > 0) begin
      check_eq("we", mon.we, q[0].we);
      if (q[0].we) begin
        check_eq("wsel", mon.wsel, q[0].wsel);
        check_eq("wdata", mon.wdata, q[0].wdata);
      end
      check_eq("br_taken", mon.br_taken, q[0].br);
      check_eq("br_target", mon.br_target, q[0].tgt);
    end
    check_eq("nzp", o_nzp, m_nzp);
    check_eq("carry", o_carry, m_carry);
    check_eq("ready", mon.ready, model_ready(i_wb_ready));
  endtask

  // drive one cycle at the negedge, check, then advance the model at the posedge
  task automatic cyc(input bit v, input bit [4:0] op, input bit [4:0] rd,
                     input bit [63:0] res, input bit wbr);
    bit   rdy;
    bit   n, z, p;
    ent_t e;
    i_valid    = v;
    i_insn     = {op, rd, 10'($urandom)};
    i_pc       = 11'($urandom);
    i_result   = res;
    i_wb_ready = wbr;
    #1;
    check_outputs();
    rdy = model_ready(wbr);
    @(posedge clk);
    if (q.size() > 0 && wbr) void'(q.pop_front());
    if (v && rdy) begin
      if (m_squash) begin
        m_squash = 1'b0;
      end else begin
        n = (m_nzp == 3'b100);
        z = (m_nzp == 3'b010);
        p = (m_nzp == 3'b001);
        e.we = op inside {[5:7], [9:16], [18:21]};
        case (op)
          5'd1:    e.br = z;
          5'd2:    e.br = z || p;
          5'd3:    e.br = n || p;
          5'd4:    e.br = n || z;
          5'd8:    e.br = 1'b1;
          default: e.br = 1'b0;
        endcase
        e.wsel  = rd;
        e.wdata = res;
        e.tgt   = e.br ? res[10:0] : 11'd0;
        if (e.we) m_nzp = res[63] ? 3'b100 : (res == 0) ? 3'b010 : 3'b001;
        if (op == 5'd16) m_carry = res[0];
        else if (op == 5'd20) m_carry = 1'b0;
        m_squash = e.br;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit [4:0]  op;
    bit [63:0] res;
    i_valid    = 1'b0;
    i_wb_ready = 1'b1;
    i_insn     = '0;
    i_pc       = '0;
    i_result   = '0;
    rst_n      = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_nzp", o_nzp, 3'b010);
    check_eq("rst_carry", o_carry, 1'b0);
    check_eq("rst_valid", mon.valid, 1'b0);

    cyc(1, 5'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    check_eq("add_we", mon.we, 1'b1);
    check_eq("add_wsel", mon.wsel, 5'd3);
    check_eq("add_nzp", o_nzp, 3'b100);
    cyc(0, 5'd0, 5'd0, 64'd0, 1);

    cyc(1, 5'd9, 5'd4, 64'd0, 1);
    cyc(1, 5'd1, 5'd0, 64'h020, 1);
    cyc(1, 5'd6, 5'd2, 64'd5, 1);
    check_eq("brz_taken", mon.br_taken, 1'b1);
    check_eq("brz_target", mon.br_target, 11'h020);
    cyc(0, 5'd0, 5'd0, 64'd0, 1);
    check_eq("squash_valid", mon.valid, 1'b0);
    check_eq("squash_nzp", o_nzp, 3'b010);

    cyc(1, 5'd16, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    check_eq("chk_carry", o_carry, 1'b1);
    cyc(1, 5'd20, 5'd1, 64'd5, 1);
    check_eq("tcs_carry", o_carry, 1'b0);
    cyc(0, 5'd0, 5'd0, 64'd0, 1);

    cyc(1, 5'd5, 5'd1, 64'd11, 0);
    cyc(1, 5'd6, 5'd2, 64'd22, 0);
    cyc(0, 5'd0, 5'd0, 64'd0, 0);
    check_eq("stall_ready", mon.ready, 1'b0);
    check_eq("stall_wsel", mon.wsel, 5'd1);
    repeat (4) cyc(0, 5'd0, 5'd0, 64'd0, 1);

    cyc(1, 5'd5, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    cyc(1, 5'd6, 5'd8, 64'd3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", mon.valid, 1'b0);
    check_eq("arst_we", mon.we, 1'b0);
    check_eq("arst_wsel", mon.wsel, 5'd0);
    check_eq("arst_wdata", mon.wdata, 64'd0);
    check_eq("arst_nzp", o_nzp, 3'b010);
    check_eq("arst_carry", o_carry, 1'b0);
    check_eq("arst_br", mon.br_taken, 1'b0);
    check_eq("arst_tgt", mon.br_target, 11'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0:       res = 64'd0;
        1:       res = {1'b1, 63'($urandom)};
        default: res = {$urandom, $urandom};
      endcase
      cyc($urandom_range(0, 3) != 0, op, 5'($urandom), res, $urandom_range(0, 2) != 0);
    end
    repeat (4) cyc(0, 5'd0, 5'd0, 64'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
